// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage and its multiply/divide unit.
package ex_pkg;

  localparam int unsigned ALU_OP_W = 5;

  // ALU operation codes; DIVU needs the fifth bit.
  typedef enum logic [ALU_OP_W-1:0] {
    AluAdd   = 5'd0,
    AluSub   = 5'd1,
    AluAnd   = 5'd2,
    AluOr    = 5'd3,
    AluXor   = 5'd4,
    AluNor   = 5'd5,
    AluSlt   = 5'd6,
    AluSltu  = 5'd7,
    AluSll   = 5'd8,
    AluSrl   = 5'd9,
    AluSra   = 5'd10,
    AluMfhi  = 5'd11,
    AluMflo  = 5'd12,
    AluMult  = 5'd13,
    AluMultu = 5'd14,
    AluDiv   = 5'd15,
    AluDivu  = 5'd16
  } alu_op_e;

  // Operand forwarding selects; any value with bit 1 set picks the MEM result.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MduIdle = 2'd0,
    MduBusy = 2'd1,
    MduFix  = 2'd2
  } mdu_state_e;

  function automatic logic is_mdu_op(alu_op_e op);
    return (op == AluMult) || (op == AluMultu) || (op == AluDiv) || (op == AluDivu);
  endfunction

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one bus.
interface ex_stage_mdu_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_BITS = 5
);
  logic                         valid_ex;
  logic [WIDTH-1:0]             readData1_ex;
  logic [WIDTH-1:0]             readData2_ex;
  logic [WIDTH-1:0]             signExtendedInst_ex;
  logic [WIDTH-1:0]             instruction_ex;
  logic [WIDTH-1:0]             icm_pc_ex;
  logic [WIDTH-1:0]             writeDataToReg_wb;
  logic [WIDTH-1:0]             aluResult_mem;
  logic [1:0]                   ForwardA;
  logic [1:0]                   ForwardB;
  logic [REG_BITS-1:0]          readReg2_ex;
  logic [REG_BITS-1:0]          writeReg_ex;
  logic                         RegDst;
  logic                         ALUSrc;
  logic [ex_pkg::ALU_OP_W-1:0]  ALUCtrl;

  logic [WIDTH-1:0]             aluResult_ex;
  logic [WIDTH-1:0]             writeDataToSRAM_ex;
  logic [WIDTH-1:0]             branchTrue_ex;
  logic [WIDTH-1:0]             jumpAddr_ex;
  logic [REG_BITS-1:0]          writeRegOut_ex;
  logic                         zero_ex;
  logic                         overflow_ex;
  logic                         carryOut_ex;
  logic                         negative_ex;
  logic                         stall_ex;
  logic                         div_by_zero_ex;
  logic [WIDTH-1:0]             hi_ex;
  logic [WIDTH-1:0]             lo_ex;

  // Pipeline side: drives the ID/EX fields, observes the results.
  modport master (
    output valid_ex, readData1_ex, readData2_ex, signExtendedInst_ex, instruction_ex,
           icm_pc_ex, writeDataToReg_wb, aluResult_mem, ForwardA, ForwardB, readReg2_ex,
           writeReg_ex, RegDst, ALUSrc, ALUCtrl,
    input  aluResult_ex, writeDataToSRAM_ex, branchTrue_ex, jumpAddr_ex, writeRegOut_ex,
           zero_ex, overflow_ex, carryOut_ex, negative_ex, stall_ex, div_by_zero_ex,
           hi_ex, lo_ex
  );

  // Execute stage side.
  modport slave (
    input  valid_ex, readData1_ex, readData2_ex, signExtendedInst_ex, instruction_ex,
           icm_pc_ex, writeDataToReg_wb, aluResult_mem, ForwardA, ForwardB, readReg2_ex,
           writeReg_ex, RegDst, ALUSrc, ALUCtrl,
    output aluResult_ex, writeDataToSRAM_ex, branchTrue_ex, jumpAddr_ex, writeRegOut_ex,
           zero_ex, overflow_ex, carryOut_ex, negative_ex, stall_ex, div_by_zero_ex,
           hi_ex, lo_ex
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, HI/LO registers.
module mdu_iter
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,          // valid MDU op sits in EX
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mdu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // {remainder|product hi, quotient|multiplier}
  logic [WIDTH-1:0]     dsor_q, dsor_d;    // divisor / multiplicand magnitude
  logic [WIDTH-1:0]     dvnd_q, dvnd_d;    // raw dividend, returned in HI on divide by 0
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 done_q, done_d;    // completed op still occupies EX this cycle
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic                 start, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       add_sum, shifted, trial;
  logic [2*WIDTH-1:0]   prod;

  assign start       = req && (state_q == MduIdle) && !done_q;
  assign stall       = start || (state_q != MduIdle);
  assign div_by_zero = (state_q == MduFix) && is_div_q && (dsor_q == '0);
  assign hi          = hi_q;
  assign lo          = lo_q;

  // Next-state, iteration datapath and sign fix-up.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dsor_d   = dsor_q;
    dvnd_d   = dvnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    add_sum  = '0;
    shifted  = '0;
    trial    = '0;
    prod     = '0;

    is_signed = (op == AluMult) || (op == AluDiv);
    a_neg     = is_signed && op_a[WIDTH-1];
    b_neg     = is_signed && op_b[WIDTH-1];
    mag_a     = a_neg ? -op_a : op_a;
    mag_b     = b_neg ? -op_b : op_b;

    unique case (state_q)
      MduIdle: begin
        if (start) begin
          state_d  = MduBusy;
          cnt_d    = CNT_W'(WIDTH - 1);
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          dsor_d   = mag_b;
          dvnd_d   = op_a;
          is_div_d = (op == AluDiv) || (op == AluDivu);
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
        end
      end
      MduBusy: begin
        if (is_div_q) begin
          shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
          trial   = shifted - {1'b0, dsor_q};
          // Bit WIDTH of the trial difference is set exactly when it borrowed.
          if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else               acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dsor_q} : '0);
          acc_d   = {add_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = MduFix;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MduFix: begin
        if (is_div_q) begin
          if (dsor_q == '0) begin
            hi_d = dvnd_q;
            lo_d = '1;
          end else begin
            lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end
        end else begin
          prod = neg_lo_q ? -acc_q : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = MduIdle;
      end
      default: state_d = MduIdle;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MduIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      dsor_q   <= '0;
      dvnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dsor_q   <= dsor_d;
      dvnd_q   <= dvnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: rtl/ex_stage_mdu.sv
// Pipelined MIPS execute stage: forwarding, ALU, branch/jump targets and the MDU stall.
module ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_BITS = 5
) (
  input  logic         clk,
  input  logic         reset,
  ex_stage_mdu_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned JW  = (WIDTH >= 28) ? 28 : WIDTH;

  alu_op_e          op;
  logic [WIDTH-1:0] op1, op2_fwd, op2, result;
  logic [WIDTH-1:0] jmask, hi, lo;
  logic [WIDTH:0]   sum_ext, sub_ext;
  logic [SHW-1:0]   shamt;
  logic             overflow, carry, mdu_stall, div_by_zero;

  assign op    = alu_op_e'(bus.ALUCtrl);
  assign shamt = op1[SHW-1:0];
  assign jmask = {WIDTH{1'b1}} << JW;

  // Operand forwarding and immediate select.
  always_comb begin
    unique case (bus.ForwardA)
      FWD_REG: op1 = bus.readData1_ex;
      FWD_WB:  op1 = bus.writeDataToReg_wb;
      default: op1 = bus.aluResult_mem;
    endcase
    unique case (bus.ForwardB)
      FWD_REG: op2_fwd = bus.readData2_ex;
      FWD_WB:  op2_fwd = bus.writeDataToReg_wb;
      default: op2_fwd = bus.aluResult_mem;
    endcase
    op2 = bus.ALUSrc ? bus.signExtendedInst_ex : op2_fwd;
  end

  // ALU result and flags; subtraction is op1 + ~op2 + 1 so carry means no borrow.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    carry    = 1'b0;
    sum_ext  = {1'b0, op1} + {1'b0, op2};
    sub_ext  = {1'b0, op1} + {1'b0, ~op2} + (WIDTH+1)'(1);
    unique case (op)
      AluAdd: begin
        result   = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = (op1[WIDTH-1] == op2[WIDTH-1]) && (result[WIDTH-1] != op1[WIDTH-1]);
      end
      AluSub: begin
        result   = sub_ext[WIDTH-1:0];
        carry    = sub_ext[WIDTH];
        overflow = (op1[WIDTH-1] != op2[WIDTH-1]) && (result[WIDTH-1] != op1[WIDTH-1]);
      end
      AluAnd:  result = op1 & op2;
      AluOr:   result = op1 | op2;
      AluXor:  result = op1 ^ op2;
      AluNor:  result = ~(op1 | op2);
      AluSlt:  result = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      AluSltu: result = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      AluSll:  result = op2 << shamt;
      AluSrl:  result = op2 >> shamt;
      AluSra:  result = $unsigned($signed(op2) >>> shamt);
      AluMfhi: result = hi;
      AluMflo: result = lo;
      default: result = '0;
    endcase
  end

  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu (
    .clk         (clk),
    .reset       (reset),
    .req         (bus.valid_ex && is_mdu_op(op) && !reset),
    .op          (op),
    .op_a        (op1),
    .op_b        (op2_fwd),
    .stall       (mdu_stall),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  assign bus.aluResult_ex       = result;
  assign bus.zero_ex            = (result == '0);
  assign bus.negative_ex        = result[WIDTH-1];
  assign bus.overflow_ex        = overflow;
  assign bus.carryOut_ex        = carry;
  assign bus.writeDataToSRAM_ex = op2_fwd;
  assign bus.writeRegOut_ex     = bus.RegDst ? bus.writeReg_ex : bus.readReg2_ex;
  assign bus.branchTrue_ex      = (bus.signExtendedInst_ex << 2) + bus.icm_pc_ex;
  assign bus.jumpAddr_ex        = (bus.icm_pc_ex & jmask) | ((bus.instruction_ex << 2) & ~jmask);
  assign bus.stall_ex           = mdu_stall && !reset;
  assign bus.div_by_zero_ex     = div_by_zero && !reset;
  assign bus.hi_ex              = hi;
  assign bus.lo_ex              = lo;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for the execute stage with multiply/divide unit.
module tb_ex_stage_mdu;
  import ex_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned RB = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage_mdu_if #(.WIDTH(W), .REG_BITS(RB)) bus ();

  ex_stage_mdu #(.WIDTH(W), .REG_BITS(RB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.valid_ex            = 1'b0;
    bus.readData1_ex        = '0;
    bus.readData2_ex        = '0;
    bus.signExtendedInst_ex = '0;
    bus.instruction_ex      = '0;
    bus.icm_pc_ex           = '0;
    bus.writeDataToReg_wb   = '0;
    bus.aluResult_mem       = '0;
    bus.ForwardA            = FWD_REG;
    bus.ForwardB            = FWD_REG;
    bus.readReg2_ex         = '0;
    bus.writeReg_ex         = '0;
    bus.RegDst              = 1'b0;
    bus.ALUSrc              = 1'b0;
    bus.ALUCtrl             = AluAdd;
  endtask

  task automatic drive_alu(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    set_idle();
    bus.valid_ex     = 1'b1;
    bus.readData1_ex = a;
    bus.readData2_ex = b;
    bus.ALUCtrl      = op;
  endtask

  // Issues one MDU op and counts stalled cycles and div-by-zero pulses until EX frees up.
  task automatic run_mdu(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int cycles, output int dbz);
    next_cycle();
    drive_alu(op, a, b);
    cycles = 0;
    dbz    = 0;
    @(negedge clk);
    while (bus.stall_ex && cycles < 100) begin
      cycles++;
      if (bus.div_by_zero_ex) dbz++;
      @(negedge clk);
    end
    if (bus.div_by_zero_ex) dbz++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.stall_ex !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_ex); end
    n_checks++; if (bus.hi_ex !== '0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.hi_ex); end
    n_checks++; if (bus.lo_ex !== '0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.lo_ex); end
    n_checks++; if (bus.div_by_zero_ex !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero_ex); end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_forwarding();
    next_cycle();
    drive_alu(AluAdd, 32'd5, 32'd3);
    bus.aluResult_mem = 32'd9;
    bus.ForwardA      = 2'b10;
    @(negedge clk);
    n_checks++; if (bus.aluResult_ex !== 32'd12) begin n_fail++; $display("FAIL fwd_a_mem: got %0d want 12", bus.aluResult_ex); end
    next_cycle();
    bus.ForwardB          = FWD_WB;
    bus.writeDataToReg_wb = 32'd7;
    @(negedge clk);
    n_checks++; if (bus.writeDataToSRAM_ex !== 32'd7) begin n_fail++; $display("FAIL fwd_b_sram: got %0d want 7", bus.writeDataToSRAM_ex); end
    n_checks++; if (bus.aluResult_ex !== 32'd16) begin n_fail++; $display("FAIL fwd_b_alu: got %0d want 16", bus.aluResult_ex); end
    next_cycle();
    bus.ALUSrc              = 1'b1;
    bus.signExtendedInst_ex = 32'd3;
    bus.readReg2_ex         = 5'd3;
    bus.writeReg_ex         = 5'd8;
    bus.RegDst              = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.aluResult_ex !== 32'd12) begin n_fail++; $display("FAIL alusrc_imm: got %0d want 12", bus.aluResult_ex); end
    n_checks++; if (bus.writeDataToSRAM_ex !== 32'd7) begin n_fail++; $display("FAIL sram_pre_mux: got %0d want 7", bus.writeDataToSRAM_ex); end
    n_checks++; if (bus.writeRegOut_ex !== 5'd8) begin n_fail++; $display("FAIL regdst_rd: got %0d want 8", bus.writeRegOut_ex); end
    next_cycle();
    bus.RegDst              = 1'b0;
    bus.signExtendedInst_ex = 32'd4;
    bus.icm_pc_ex           = 32'hA000_0100;
    bus.instruction_ex      = 32'h0800_0010;
    @(negedge clk);
    n_checks++; if (bus.writeRegOut_ex !== 5'd3) begin n_fail++; $display("FAIL regdst_rt: got %0d want 3", bus.writeRegOut_ex); end
    n_checks++; if (bus.branchTrue_ex !== 32'hA000_0110) begin n_fail++; $display("FAIL branch: got %h want a0000110", bus.branchTrue_ex); end
    n_checks++; if (bus.jumpAddr_ex !== 32'hA000_0040) begin n_fail++; $display("FAIL jump: got %h want a0000040", bus.jumpAddr_ex); end
  endtask

  task automatic test_alu_flags();
    next_cycle();
    drive_alu(AluAdd, 32'h7FFF_FFFF, 32'd1);
    @(negedge clk);
    n_checks++; if (bus.aluResult_ex !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_result: got %h want 80000000", bus.aluResult_ex); end
    n_checks++; if (bus.overflow_ex !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.overflow_ex); end
    n_checks++; if (bus.negative_ex !== 1'b1) begin n_fail++; $display("FAIL ovf_neg: got %b want 1", bus.negative_ex); end
    n_checks++; if (bus.carryOut_ex !== 1'b0) begin n_fail++; $display("FAIL ovf_carry: got %b want 0", bus.carryOut_ex); end
    next_cycle();
    drive_alu(AluSub, 32'd4, 32'd4);
    @(negedge clk);
    n_checks++; if (bus.zero_ex !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %b want 1", bus.zero_ex); end
    n_checks++; if (bus.carryOut_ex !== 1'b1) begin n_fail++; $display("FAIL sub_carry: got %b want 1", bus.carryOut_ex); end
    n_checks++; if (bus.overflow_ex !== 1'b0) begin n_fail++; $display("FAIL sub_ovf: got %b want 0", bus.overflow_ex); end
    next_cycle();
    drive_alu(AluSlt, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    n_checks++; if (bus.aluResult_ex !== 32'd1) begin n_fail++; $display("FAIL slt: got %h want 1", bus.aluResult_ex); end
    next_cycle();
    drive_alu(AluSltu, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    n_checks++; if (bus.aluResult_ex !== 32'd0) begin n_fail++; $display("FAIL sltu: got %h want 0", bus.aluResult_ex); end
  endtask

  task automatic test_mult();
    int cyc, dbz;
    run_mdu(AluMult, 32'hFFFF_FFFD, 32'd7, cyc, dbz);
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL mult_stall_len: got %0d want 34", cyc); end
    n_checks++; if (bus.hi_ex !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi_ex); end
    n_checks++; if (bus.lo_ex !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", bus.lo_ex); end
    n_checks++; if (bus.aluResult_ex !== '0) begin n_fail++; $display("FAIL mult_alu_zero: got %h want 0", bus.aluResult_ex); end
    run_mdu(AluMultu, 32'hFFFF_FFFF, 32'd2, cyc, dbz);
    n_checks++; if (bus.hi_ex !== 32'd1) begin n_fail++; $display("FAIL multu_hi: got %h want 1", bus.hi_ex); end
    n_checks++; if (bus.lo_ex !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffe", bus.lo_ex); end
  endtask

  task automatic test_div();
    int cyc, dbz;
    run_mdu(AluDiv, 32'hFFFF_FFF9, 32'd2, cyc, dbz);
    n_checks++; if (bus.lo_ex !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", bus.lo_ex); end
    n_checks++; if (bus.hi_ex !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", bus.hi_ex); end
    n_checks++; if (dbz !== 0) begin n_fail++; $display("FAIL div_no_dbz: got %0d want 0", dbz); end
    run_mdu(AluDiv, 32'd5, 32'd0, cyc, dbz);
    n_checks++; if (bus.lo_ex !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h want ffffffff", bus.lo_ex); end
    n_checks++; if (bus.hi_ex !== 32'd5) begin n_fail++; $display("FAIL div0_hi: got %h want 5", bus.hi_ex); end
    n_checks++; if (dbz !== 1) begin n_fail++; $display("FAIL div0_pulse: got %0d cycles want 1", dbz); end
    run_mdu(AluDiv, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dbz);
    n_checks++; if (bus.lo_ex !== 32'h8000_0000) begin n_fail++; $display("FAIL divmin_lo: got %h want 80000000", bus.lo_ex); end
    n_checks++; if (bus.hi_ex !== 32'd0) begin n_fail++; $display("FAIL divmin_hi: got %h want 0", bus.hi_ex); end
    n_checks++; if (dbz !== 0) begin n_fail++; $display("FAIL divmin_dbz: got %0d want 0", dbz); end
    run_mdu(AluDivu, 32'd100, 32'd7, cyc, dbz);
    n_checks++; if (bus.lo_ex !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %0d want 14", bus.lo_ex); end
    n_checks++; if (bus.hi_ex !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %0d want 2", bus.hi_ex); end
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL divu_stall_len: got %0d want 34", cyc); end
  endtask

  task automatic test_mflo_after_div();
    int cyc;
    next_cycle();
    drive_alu(AluDiv, 32'd20, 32'd3);
    @(negedge clk);
    cyc = bus.stall_ex ? 1 : 0;
    next_cycle();
    drive_alu(AluMflo, 32'd0, 32'd0);
    @(negedge clk);
    while (bus.stall_ex && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL mflo_stall_len: got %0d want 34", cyc); end
    n_checks++; if (bus.aluResult_ex !== 32'd6) begin n_fail++; $display("FAIL mflo_value: got %0d want 6", bus.aluResult_ex); end
  endtask

  task automatic test_reset_mid_op();
    int cyc, dbz;
    next_cycle();
    drive_alu(AluMultu, 32'd123, 32'd456);
    @(negedge clk);
    repeat (10) @(negedge clk);
    n_checks++; if (bus.stall_ex !== 1'b1) begin n_fail++; $display("FAIL busy_stall: got %b want 1", bus.stall_ex); end
    next_cycle();
    reset = 1'b1;
    set_idle();
    @(negedge clk);
    n_checks++; if (bus.stall_ex !== 1'b0) begin n_fail++; $display("FAIL rst_cycle_stall: got %b want 0", bus.stall_ex); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.stall_ex !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b want 0", bus.stall_ex); end
    n_checks++; if (bus.hi_ex !== '0) begin n_fail++; $display("FAIL midrst_hi: got %h want 0", bus.hi_ex); end
    n_checks++; if (bus.lo_ex !== '0) begin n_fail++; $display("FAIL midrst_lo: got %h want 0", bus.lo_ex); end
    run_mdu(AluMultu, 32'd6, 32'd7, cyc, dbz);
    n_checks++; if (bus.lo_ex !== 32'd42) begin n_fail++; $display("FAIL fresh_lo: got %0d want 42", bus.lo_ex); end
    n_checks++; if (bus.hi_ex !== 32'd0) begin n_fail++; $display("FAIL fresh_hi: got %0d want 0", bus.hi_ex); end
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL fresh_stall_len: got %0d want 34", cyc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_alu_flags();
    test_mult();
    test_div();
    test_mflo_after_div();
    test_reset_mid_op();
    next_cycle();
    set_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
